swu_frame_sequencer: RTL and testbench

SWU_FRAME_SEQUENCER -- requirements
Module: swu_frame_sequencer

---
 rtl/swu_frame_sequencer.sv | 147 ++++++++++++++
 tb/tb_swu_frame_sequencer.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/swu_frame_sequencer.sv
// Frame-level handshake sequencer around a sliding-window unit: gates input and
// output streams per frame, pulses the window unit's reset between frames.
module swu_frame_sequencer #(
  parameter int SIMD          = 1,
  parameter int MMV           = 2,
  parameter int IFMChannels   = 2,
  parameter int IFMWidth      = 8,
  parameter int IFMHeight     = 8,
  parameter int KERNEL_WIDTH  = 3,
  parameter int KERNEL_HEIGHT = 3,
  parameter int OFMWidth      = 6,
  parameter int OFMHeight     = 6,
  parameter int RESET_CYCLES  = 2
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        enable,
  input  logic        s_tvalid,
  output logic        s_tready,
  output logic        swu_in_tvalid,
  input  logic        swu_in_tready,
  input  logic        swu_out_tvalid,
  output logic        swu_out_tready,
  output logic        m_tvalid,
  input  logic        m_tready,
  output logic        swu_resetn,
  output logic        frame_done,
  output logic [15:0] frame_count,
  output logic        busy,
  output logic        protocol_err
);

  localparam int IN_WORDS  = IFMHeight * IFMWidth * IFMChannels / (SIMD * MMV);
  localparam int OUT_WORDS = OFMHeight * OFMWidth * KERNEL_HEIGHT * KERNEL_WIDTH * IFMChannels / SIMD;
  localparam int IN_W      = $clog2(IN_WORDS + 1);
  localparam int OUT_W     = $clog2(OUT_WORDS + 1);
  localparam int RC_W      = $clog2(RESET_CYCLES + 1);

  localparam logic [IN_W-1:0]  IN_LAST  = IN_W'(IN_WORDS - 1);
  localparam logic [IN_W-1:0]  IN_ONE   = IN_W'(1);
  localparam logic [OUT_W-1:0] OUT_LAST = OUT_W'(OUT_WORDS - 1);
  localparam logic [OUT_W-1:0] OUT_ONE  = OUT_W'(1);
  localparam logic [RC_W-1:0]  RC_LAST  = RC_W'(RESET_CYCLES - 1);
  localparam logic [RC_W-1:0]  RC_ONE   = RC_W'(1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    FLUSH = 2'd3
  } state_t;

  state_t           state_r, state_next_s;
  logic [IN_W-1:0]  in_cnt_r;
  logic [OUT_W-1:0] out_cnt_r;
  logic [RC_W-1:0]  rst_cnt_r;
  logic [15:0]      frame_count_r;
  logic             frame_done_r, swu_resetn_r, protocol_err_r;

  logic in_open_s, out_open_s, in_acc_s, out_acc_s;
  logic in_last_s, out_last_s, flush_last_s, flush_entry_s, err_s;

  assign in_open_s     = (state_r == RUN);
  assign out_open_s    = (state_r == RUN) || (state_r == DRAIN);
  assign in_acc_s      = in_open_s & s_tvalid & swu_in_tready;
  assign out_acc_s     = out_open_s & swu_out_tvalid & m_tready;
  assign in_last_s     = in_acc_s & (in_cnt_r == IN_LAST);
  assign out_last_s    = out_acc_s & (out_cnt_r == OUT_LAST);
  assign flush_last_s  = (rst_cnt_r == RC_LAST);
  assign flush_entry_s = (state_next_s == FLUSH) && (state_r != FLUSH);

  // Handshake gating is purely combinational so no latency is added on any path.
  assign swu_in_tvalid  = in_open_s & s_tvalid;
  assign s_tready       = in_open_s & swu_in_tready;
  assign m_tvalid       = out_open_s & swu_out_tvalid;
  assign swu_out_tready = out_open_s & m_tready;

  assign swu_resetn   = swu_resetn_r;
  assign frame_done   = frame_done_r;
  assign frame_count  = frame_count_r;
  assign protocol_err = protocol_err_r;
  assign busy         = (state_r != IDLE);

  // Next-state decode; finishing outputs while inputs are still short flags an error.
  always_comb begin
    state_next_s = state_r;
    err_s        = 1'b0;
    case (state_r)
      IDLE: begin
        if (enable) state_next_s = RUN;
        else        state_next_s = IDLE;
      end
      RUN: begin
        if (out_last_s && !in_last_s) begin
          state_next_s = FLUSH;
          err_s        = 1'b1;
        end else if (out_last_s) begin
          state_next_s = FLUSH;
        end else if (in_last_s) begin
          state_next_s = DRAIN;
        end else begin
          state_next_s = RUN;
        end
      end
      DRAIN: begin
        if (out_last_s) state_next_s = FLUSH;
        else            state_next_s = DRAIN;
      end
      FLUSH: begin
        if (flush_last_s) state_next_s = enable ? RUN : IDLE;
        else              state_next_s = FLUSH;
      end
      default: state_next_s = IDLE;
    endcase
  end

  // State, counters and registered status outputs.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_r        <= IDLE;
      in_cnt_r       <= '0;
      out_cnt_r      <= '0;
      rst_cnt_r      <= '0;
      frame_count_r  <= 16'd0;
      frame_done_r   <= 1'b0;
      swu_resetn_r   <= 1'b0;
      protocol_err_r <= 1'b0;
    end else begin
      state_r      <= state_next_s;
      frame_done_r <= flush_entry_s;
      swu_resetn_r <= (state_next_s != FLUSH);
      if (flush_entry_s) begin
        in_cnt_r      <= '0;
        out_cnt_r     <= '0;
        frame_count_r <= frame_count_r + 16'd1;
      end else begin
        if (in_acc_s)  in_cnt_r  <= in_cnt_r + IN_ONE;
        if (out_acc_s) out_cnt_r <= out_cnt_r + OUT_ONE;
      end
      // Counts cycles spent in FLUSH; cleared on any other state.
      if ((state_r == FLUSH) && (state_next_s == FLUSH)) rst_cnt_r <= rst_cnt_r + RC_ONE;
      else                                                rst_cnt_r <= '0;
      if (err_s) protocol_err_r <= 1'b1;
    end
  end

endmodule

// File: tb/tb_swu_frame_sequencer.sv
// Randomized and directed bench for swu_frame_sequencer, checked every cycle
// against a count-based frame model.
module tb_swu_frame_sequencer;

  localparam int IN_WORDS  = 16;
  localparam int OUT_WORDS = 72;
  localparam int RC        = 2;

  localparam int M_NOOUT = 0;
  localparam int M_FULL  = 1;
  localparam int M_SIMUL = 2;
  localparam int M_EARLY = 3;
  localparam int M_RAND  = 4;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        enable = 1'b0;
  logic        s_tvalid = 1'b0, s_tready;
  logic        swu_in_tvalid, swu_in_tready = 1'b0;
  logic        swu_out_tvalid = 1'b0, swu_out_tready;
  logic        m_tvalid, m_tready = 1'b0;
  logic        swu_resetn, frame_done, busy, protocol_err;
  logic [15:0] frame_count;

  int n_vec = 0;
  int n_err = 0;

  // model state: frame progress expressed as plain counts
  bit m_active = 1'b0;
  int m_in = 0, m_out = 0, m_flush = 0, m_cnt = 0;
  bit m_done = 1'b0, m_err = 1'b0, m_srn = 1'b0;
  bit drop_en = 1'b0;

  swu_frame_sequencer #(
    .SIMD(1), .MMV(2), .IFMChannels(2), .IFMWidth(4), .IFMHeight(4),
    .KERNEL_WIDTH(3), .KERNEL_HEIGHT(3), .OFMWidth(2), .OFMHeight(2),
    .RESET_CYCLES(RC)
  ) dut (
    .clk(clk), .resetn(resetn), .enable(enable),
    .s_tvalid(s_tvalid), .s_tready(s_tready),
    .swu_in_tvalid(swu_in_tvalid), .swu_in_tready(swu_in_tready),
    .swu_out_tvalid(swu_out_tvalid), .swu_out_tready(swu_out_tready),
    .m_tvalid(m_tvalid), .m_tready(m_tready),
    .swu_resetn(swu_resetn), .frame_done(frame_done), .frame_count(frame_count),
    .busy(busy), .protocol_err(protocol_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic check_all();
    bit in_open, out_open;
    in_open  = m_active && (m_flush == 0) && (m_in < IN_WORDS);
    out_open = m_active && (m_flush == 0);
    chk("swu_in_tvalid", swu_in_tvalid, in_open & s_tvalid);
    chk("s_tready", s_tready, in_open & swu_in_tready);
    chk("m_tvalid", m_tvalid, out_open & swu_out_tvalid);
    chk("swu_out_tready", swu_out_tready, out_open & m_tready);
    chk("busy", busy, m_active);
    chk("swu_resetn", swu_resetn, m_srn);
    chk("frame_done", frame_done, m_done);
    chk("frame_count", frame_count, m_cnt);
    chk("protocol_err", protocol_err, m_err);
  endtask

  task automatic model_update();
    bit in_open, out_open;
    in_open  = m_active && (m_flush == 0) && (m_in < IN_WORDS);
    out_open = m_active && (m_flush == 0);
    m_done = 1'b0;
    if (!resetn) begin
      m_active = 1'b0; m_in = 0; m_out = 0; m_flush = 0;
      m_cnt = 0; m_err = 1'b0;
    end else if (!m_active) begin
      m_active = enable;
    end else if (m_flush > 0) begin
      m_flush--;
      if (m_flush == 0) m_active = enable;
    end else begin
      if (in_open && s_tvalid && swu_in_tready) m_in++;
      if (out_open && swu_out_tvalid && m_tready) m_out++;
      if (m_out == OUT_WORDS) begin
        if (m_in < IN_WORDS) m_err = 1'b1;
        m_done = 1'b1;
        m_cnt = (m_cnt + 1) % 65536;
        m_in = 0; m_out = 0; m_flush = RC;
      end
    end
    m_srn = resetn && (m_flush == 0);
  endtask

  task automatic set_inputs(input int mode);
    case (mode)
      M_NOOUT: begin
        s_tvalid = 1'b1; swu_in_tready = 1'b1; swu_out_tvalid = 1'b0; m_tready = 1'b1;
      end
      M_FULL: begin
        s_tvalid = 1'b1; swu_in_tready = 1'b1; m_tready = 1'b1;
        swu_out_tvalid = (m_in == IN_WORDS);
      end
      M_SIMUL: begin
        s_tvalid = (m_in < IN_WORDS - 1) || (m_out == OUT_WORDS - 1);
        swu_in_tready = 1'b1; m_tready = 1'b1;
        swu_out_tvalid = (m_out < OUT_WORDS - 1) || (m_in == IN_WORDS - 1);
      end
      M_EARLY: begin
        s_tvalid = (m_in < 10); swu_in_tready = 1'b1;
        swu_out_tvalid = 1'b1; m_tready = 1'b1;
      end
      default: begin
        s_tvalid = ($urandom_range(0, 3) != 0);
        swu_in_tready = ($urandom_range(0, 3) != 0);
        m_tready = ($urandom_range(0, 3) != 0);
        swu_out_tvalid = ($urandom_range(0, 3) != 0) &&
                         ((m_out + 1) * IN_WORDS <= m_in * OUT_WORDS);
      end
    endcase
    if (drop_en) enable = !((m_in == IN_WORDS) || (m_flush > 0));
  endtask

  // inputs are set at the falling edge; outputs checked 1 time unit later
  task automatic step(input int mode);
    set_inputs(mode);
    #1;
    check_all();
    @(posedge clk);
    model_update();
    @(negedge clk);
  endtask

  task automatic run_frame(input int mode, input int bound);
    int start;
    int n;
    start = m_cnt;
    n = 0;
    while (!((m_cnt != start) && (m_flush == 0)) && (n < bound)) begin
      step(mode);
      n++;
    end
    chk("frame_end_count", frame_count, (start + 1) % 65536);
  endtask

  initial begin
    int n;
    @(negedge clk);
    repeat (3) step(M_NOOUT);
    resetn = 1'b1;
    repeat (2) step(M_NOOUT);

    // reset mid-frame after 5 inputs
    enable = 1'b1;
    n = 0;
    while ((m_in < 5) && (n < 50)) begin
      step(M_NOOUT);
      n++;
    end
    chk("mid_in_reached", dut.in_cnt_r, 5);
    resetn = 1'b0;
    step(M_NOOUT);
    resetn = 1'b1;
    chk("mid_rst_fc", frame_count, 0);
    step(M_NOOUT);

    run_frame(M_FULL, 300);
    run_frame(M_SIMUL, 300);

    // enable dropped in DRAIN: frame completes, then IDLE
    drop_en = 1'b1;
    run_frame(M_FULL, 300);
    drop_en = 1'b0;
    enable = 1'b0;
    repeat (3) step(M_FULL);
    enable = 1'b1;
    repeat (2) step(M_FULL);

    repeat (4) run_frame(M_RAND, 3000);
    run_frame(M_EARLY, 300);
    run_frame(M_RAND, 3000);
    repeat (5) step(M_RAND);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
